// File: rtl/serial_bus_pkg.sv
// ----------------------------------------------------------------------------
// serial_bus_pkg : shared states and line constants for the serial bus blocks
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package serial_bus_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ID        = 4'd1,
    ST_RW        = 4'd2,
    ST_ADDR      = 4'd3,
    ST_DATA      = 4'd4,
    ST_STOP      = 4'd5,
    ST_ACK       = 4'd6,
    ST_RD_GAP    = 4'd7,
    ST_RD_START  = 4'd8,
    ST_RD_DATA   = 4'd9,
    ST_RD_STOP   = 4'd10,
    ST_WAIT_HIGH = 4'd11
  } slave_state_t;

  localparam logic START_BIT  = 1'b0;
  localparam logic STOP_BIT   = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  localparam int ID_W = 2;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

`default_nettype wire

// File: rtl/serial_slave_if.sv
// ----------------------------------------------------------------------------
// serial_slave_if : serial line bundle between a bus master and a slave
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface serial_slave_if;
  logic rx;
  logic tx;
  logic busy;
  logic frame_err;

  modport master (output rx, input tx, input busy, input frame_err);
  modport slave  (input rx, output tx, output busy, output frame_err);
endinterface

`default_nettype wire

// File: rtl/serial_slave_regfile.sv
// ----------------------------------------------------------------------------
// serial_slave_regfile : 2^ADDR_W x DATA_W registers, sync write, comb read
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_slave_regfile #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  input  wire logic              i_we,
  input  wire logic [ADDR_W-1:0] i_waddr,
  input  wire logic [DATA_W-1:0] i_wdata,
  input  wire logic [ADDR_W-1:0] i_raddr,
  output logic      [DATA_W-1:0] o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/serial_slave.sv
// ----------------------------------------------------------------------------
// serial_slave : bit-serial frame decoder with register file, ACK and read reply
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module serial_slave
  import serial_bus_pkg::*;
#(
  parameter logic [ID_W-1:0] SLAVE_ID   = 2'b01,
  parameter int              ADDR_W     = 4,
  parameter int              DATA_W     = 8,
  parameter int              ACK_CYCLES = 4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  serial_slave_if.slave bus
);

  localparam int MAX_A   = (ADDR_W > ID_W) ? ADDR_W : ID_W;
  localparam int MAX_B   = (DATA_W > ACK_CYCLES) ? DATA_W : ACK_CYCLES;
  localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  slave_state_t      r_state;
  slave_state_t      w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_len;
  logic              w_last;
  logic [ID_W-1:0]   r_id;
  logic              r_rw;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [DATA_W-1:0] w_mem_rdata;
  logic              w_id_match;
  logic              w_we;
  logic              w_ferr;
  logic              w_tx;
  logic              r_tx;
  logic              r_ferr;

  assign w_id_match = (r_id == SLAVE_ID);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    w_len  = CNT_W'(1);
    w_we   = 1'b0;
    w_ferr = 1'b0;
    w_tx   = IDLE_LEVEL;

    case (r_state)
      ST_ID:      w_len = CNT_W'(ID_W);
      ST_ADDR:    w_len = CNT_W'(ADDR_W);
      ST_DATA:    w_len = CNT_W'(DATA_W);
      ST_ACK:     w_len = CNT_W'(ACK_CYCLES);
      ST_RD_DATA: w_len = CNT_W'(DATA_W);
      default:    w_len = CNT_W'(1);
    endcase
    w_last = (r_cnt == (w_len - 1'b1));

    case (r_state)
      ST_IDLE: if (bus.rx == START_BIT) w_next = ST_ID;
      ST_ID:   if (w_last) w_next = ST_RW;
      ST_RW:   w_next = ST_ADDR;
      ST_ADDR: if (w_last) w_next = (r_rw == RW_WRITE) ? ST_DATA : ST_STOP;
      ST_DATA: if (w_last) w_next = ST_STOP;
      ST_STOP: begin
        if (bus.rx != STOP_BIT) begin
          w_ferr = 1'b1;
          w_next = ST_WAIT_HIGH;
        end else if (w_id_match) begin
          w_we   = (r_rw == RW_WRITE);
          w_next = ST_ACK;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ACK: begin
        w_tx = 1'b0;
        if (w_last) w_next = (r_rw == RW_WRITE) ? ST_IDLE : ST_RD_GAP;
      end
      ST_RD_GAP:   w_next = ST_RD_START;
      ST_RD_START: begin
        w_tx   = 1'b0;
        w_next = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        w_tx = r_rdata[DATA_W-1];
        if (w_last) w_next = ST_RD_STOP;
      end
      ST_RD_STOP:   w_next = ST_IDLE;
      ST_WAIT_HIGH: if (bus.rx == IDLE_LEVEL) w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  // Field shifting, response latch and registered line outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= '0;
      r_id    <= '0;
      r_rw    <= RW_READ;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_tx    <= IDLE_LEVEL;
      r_ferr  <= 1'b0;
    end else begin
      r_cnt  <= (w_next != r_state) ? '0 : r_cnt + 1'b1;
      r_tx   <= w_tx;
      r_ferr <= w_ferr;
      case (r_state)
        ST_ID:      r_id    <= {r_id[ID_W-2:0], bus.rx};
        ST_RW:      r_rw    <= bus.rx;
        ST_ADDR:    r_addr  <= {r_addr[ADDR_W-2:0], bus.rx};
        ST_DATA:    r_wdata <= {r_wdata[DATA_W-2:0], bus.rx};
        ST_STOP:    r_rdata <= w_mem_rdata;
        ST_RD_DATA: r_rdata <= {r_rdata[DATA_W-2:0], 1'b0};
        default:    ;
      endcase
    end
  end

  serial_slave_regfile #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_regfile (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (r_wdata),
    .i_raddr (r_addr),
    .o_rdata (w_mem_rdata)
  );

  assign bus.tx        = r_tx;
  assign bus.frame_err = r_ferr;
  assign bus.busy      = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_slave.sv
// ----------------------------------------------------------------------------
// tb_serial_slave : directed frames against serial_slave with fixed expectations
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_serial_slave;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  serial_slave_if bus ();

  serial_slave #(
    .SLAVE_ID   (2'b01),
    .ADDR_W     (4),
    .DATA_W     (8),
    .ACK_CYCLES (4)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bit per call: rx is set, sampled on the next rising edge, then #1 later.
  task automatic send_bit(input logic b);
    bus.rx = b;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [1:0] id, input logic rw, input logic [3:0] addr,
                            input logic [7:0] data, input logic stop);
    send_bit(1'b0);
    for (int i = 1; i >= 0; i--) send_bit(id[i]);
    send_bit(rw);
    for (int i = 3; i >= 0; i--) send_bit(addr[i]);
    if (rw) for (int i = 7; i >= 0; i--) send_bit(data[i]);
    send_bit(stop);
  endtask

  task automatic capture(input int n, input logic toggle, output logic [31:0] v);
    v = '0;
    for (int i = 0; i < n; i++) begin
      bus.rx = (toggle && i < 15) ? i[0] : 1'b1;
      @(posedge clk);
      #1;
      v = {v[30:0], bus.tx};
    end
    bus.rx = 1'b1;
  endtask

  function automatic logic [31:0] exp_read(input logic [7:0] d);
    return {16'h0, 4'b0000, 1'b1, 1'b0, d, 2'b11};
  endfunction

  task automatic do_read(input string tag, input logic [3:0] addr, input logic [7:0] exp,
                         input logic toggle);
    logic [31:0] v;
    send_frame(2'b01, 1'b0, addr, 8'h00, 1'b1);
    capture(16, toggle, v);
    check_vec(tag, v, exp_read(exp));
  endtask

  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1;
    check_vec("rst_async_tx", {31'h0, bus.tx}, 32'h1);
    check_vec("rst_async_busy", {31'h0, bus.busy}, 32'h0);
    @(negedge clk);
    rst    = 1'b0;
    bus.rx = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] v;
    int          ferr_sum;
    int          tx_low;
    n_vec  = 0;
    n_err  = 0;
    rst    = 1'b1;
    bus.rx = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_vec("reset_tx", {31'h0, bus.tx}, 32'h1);
    check_vec("reset_busy", {31'h0, bus.busy}, 32'h0);
    check_vec("reset_ferr", {31'h0, bus.frame_err}, 32'h0);

    // Write then read back.
    send_frame(2'b01, 1'b1, 4'h3, 8'hA5, 1'b1);
    capture(8, 1'b0, v);
    check_vec("write_ack", v, 32'h0000_000F);
    do_read("read_a5", 4'h3, 8'hA5, 1'b0);

    // Foreign ID is ignored.
    send_frame(2'b10, 1'b1, 4'h3, 8'hFF, 1'b1);
    check_vec("idfilt_busy", {31'h0, bus.busy}, 32'h0);
    capture(8, 1'b0, v);
    check_vec("idfilt_tx", v, 32'h0000_00FF);
    do_read("idfilt_read", 4'h3, 8'hA5, 1'b0);

    // Bad stop bit, line held low.
    send_frame(2'b01, 1'b1, 4'h3, 8'h00, 1'b0);
    check_vec("ferr_pulse", {31'h0, bus.frame_err}, 32'h1);
    ferr_sum = 0;
    tx_low   = 0;
    for (int i = 0; i < 5; i++) begin
      send_bit(1'b0);
      ferr_sum += int'(bus.frame_err);
      tx_low   += int'(!bus.tx);
    end
    check_vec("ferr_single", ferr_sum, 32'd0);
    check_vec("ferr_no_ack", tx_low, 32'd0);
    check_vec("ferr_wait_busy", {31'h0, bus.busy}, 32'h1);
    send_bit(1'b1);
    check_vec("ferr_idle_busy", {31'h0, bus.busy}, 32'h0);
    do_read("ferr_read", 4'h3, 8'hA5, 1'b0);

    // Back-to-back writes, second start on the first IDLE cycle.
    send_frame(2'b01, 1'b1, 4'h0, 8'h11, 1'b1);
    capture(4, 1'b0, v);
    check_vec("b2b_ack1", v, 32'h0);
    send_frame(2'b01, 1'b1, 4'hF, 8'h22, 1'b1);
    capture(8, 1'b0, v);
    check_vec("b2b_ack2", v, 32'h0000_000F);
    do_read("b2b_read0", 4'h0, 8'h11, 1'b0);
    do_read("b2b_readF", 4'hF, 8'h22, 1'b0);

    // rx toggling during a read reply.
    do_read("toggle_read", 4'h3, 8'hA5, 1'b1);
    check_vec("toggle_idle", {31'h0, bus.busy}, 32'h0);
    do_read("after_toggle", 4'hF, 8'h22, 1'b0);

    // Reset in the middle of an ACK window.
    send_frame(2'b01, 1'b1, 4'h5, 8'h3C, 1'b1);
    capture(2, 1'b0, v);
    check_vec("ack_before_rst", v, 32'h0);
    pulse_reset();
    do_read("rst_ack_read", 4'h5, 8'h00, 1'b0);

    // Reset in the middle of the ADDR field.
    send_frame(2'b01, 1'b1, 4'h3, 8'hA5, 1'b1);
    capture(8, 1'b0, v);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    pulse_reset();
    do_read("rst_addr_read", 4'h3, 8'h00, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_slave.md
# serial_slave

Bus-side slave endpoint that consumes the bit-serial frames driven on a master's `tx` line and produces the acknowledge/response stream the master samples on its `rx` input. It decodes a fixed-format frame, filters on its own slave ID, updates or reads a small local register file, pulls the shared response line low for a fixed acknowledge window, and for reads returns a data frame. One bit is transferred per `clk` cycle, with no oversampling.

## Interface
- `SLAVE_ID`, default 2'b01: slave ID this endpoint answers to.
- `ADDR_W`, default 4: register offset width; the register file holds 2^ADDR_W words.
- `DATA_W`, default 8: data word width.
- `ACK_CYCLES`, default 4: number of cycles `tx` is held low as the acknowledge.
- `clk`, input, 1: single clock; all sampling on the rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `rx`, input, 1: serial line from the master's `tx`; idles high.
- `tx`, output, 1: serial response line to the master's `rx`; idles high.
- `busy`, output, 1: high from start-bit detection until return to IDLE.
- `frame_err`, output, 1: one-cycle pulse when a sampled stop bit is 0.

## Operation
- Frame format, sampled one bit per cycle, with ID, address and data sent MSB first:
  - start bit (0), then ID[1:0], then RW (1 = write, 0 = read), then ADDR[ADDR_W-1:0];
  - for writes only, DATA[DATA_W-1:0];
  - stop bit (1).
- State machine: IDLE → ID → RW → ADDR → (DATA if RW=1) → STOP → ACK → (RD_GAP → RD_START → RD_DATA → RD_STOP if read) → IDLE. One additional state, WAIT_HIGH, handles errors.
- IDLE: when `rx` is sampled 0, go to ID. Each field state counts exactly its width in cycles.
- STOP:
  - `rx`=1 and ID matches: a write commits mem[ADDR] ← DATA on this edge; go to ACK.
  - `rx`=1 and ID does not match: return to IDLE silently. There is no write and no ACK.
  - `rx`=0: pulse `frame_err`, perform no write and no ACK, and go to WAIT_HIGH.
- WAIT_HIGH: stay until `rx` is sampled 1, then go to IDLE. This prevents a stuck-low line from being read as repeated start bits.
- ACK: `tx`=0 for ACK_CYCLES cycles.
  - Write: go to IDLE afterwards.
  - Read: go to RD_GAP afterwards.
- Read response, in order:
  - RD_GAP: one cycle with `tx`=1.
  - RD_START: one cycle with `tx`=0.
  - RD_DATA: DATA_W cycles, driving mem[ADDR] MSB first.
  - RD_STOP: one cycle with `tx`=1, then IDLE.
- Read data is latched at the STOP edge. A write to the same address in a later frame cannot alter a response already in flight.
- `rx` is ignored in ACK and in all RD_* states. The bus is half-duplex by protocol.
- An address is always in range because ADDR_W fully indexes the register file.

## Timing
- Reset: `tx`=1, `busy`=0, `frame_err`=0, state IDLE, all register words 0. Reset asserted mid-frame or mid-response aborts immediately. `tx` returns high asynchronously, and no partial write occurs.
- `tx` and `frame_err` are registered outputs.
- Start bit is sampled at edge N:
  - write frame: the stop bit is sampled at edge N+1+2+1+ADDR_W+DATA_W (N+16 at defaults);
  - read frame: the stop bit is sampled at edge N+1+2+1+ADDR_W (N+8 at defaults).
- The cycle after the stop bit is sampled at edge S:
  - `tx` goes low at S+1 and stays low through S+ACK_CYCLES;
  - for reads, the gap bit is driven at S+ACK_CYCLES+1 and the start bit at S+ACK_CYCLES+2;
  - data bit DATA_W-1 is driven at S+ACK_CYCLES+3.
- `busy` rises the cycle after start detection. It falls the cycle the state returns to IDLE, and stays high through WAIT_HIGH.
- Back-to-back frames: a new start bit may be sampled on the first IDLE cycle after ACK for writes, after RD_STOP for reads, or after a non-matching stop bit.

## Structure
- Shared package `serial_bus_pkg` holds:
  - the `slave_state_t` enum;
  - START_BIT=0, STOP_BIT=1 and IDLE_LEVEL=1;
  - ID_W=2;
  - the RW encoding constants.
- The package is reused by the master and any arbiter.
- One sub-module, `serial_slave_regfile`: a 2^ADDR_W × DATA_W register file with synchronous write, combinational read, and async clear on `rst`.
- FSM, bit counter, shift register and output registers all live in `serial_slave`.

## Test plan
- **Reset:** assert `rst` mid-ADDR field of a write frame → `tx`=1 and `busy`=0 immediately; a subsequent read of that address returns 8'h00.
- **Write:** send write frame ID=01, ADDR=4'h3, DATA=8'hA5 → `tx` low for exactly 4 cycles starting the cycle after the stop bit, then high. Follow with a read of 4'h3 → ACK, one gap bit, start bit, then 1,0,1,0,0,1,0,1, then stop.
- **ID filter:** write frame ID=10, ADDR=4'h3, DATA=8'hFF → `tx` stays 1 throughout. A subsequent read of 4'h3 still returns 8'hA5.
- **Framing error:** write frame with stop bit 0 and `rx` held 0 for 5 more cycles → one `frame_err` pulse, no ACK, no further start detection until `rx`=1. Read-back shows the register is unchanged.
- **Back-to-back writes:** write 4'h0←8'h11, then immediately write 4'hF←8'h22 starting on the first IDLE cycle → two separate ACK windows. Read-back returns 8'h11 and 8'h22.
- **Read ignores bus:** during a read response, toggle `rx` → the response bits are unaffected and no new frame is decoded.
